// File: rtl/pixel_writer_if.sv
// Pixel stream and frame-buffer write port bundle for pixel_writer.
// master drives the pixel stream and stall; slave is the writer itself.
interface pixel_writer_if;
  logic        i_valid;
  logic [9:0]  i_pixel_x;
  logic [9:0]  i_pixel_y;
  logic [23:0] i_color;
  logic        o_ready;
  logic        i_stall;
  logic        o_we;
  logic [18:0] o_addr;
  logic [23:0] o_data;
  logic        o_frame_done;
  logic [15:0] o_drop_count;

  modport master (
    output i_valid, i_pixel_x, i_pixel_y, i_color, i_stall,
    input  o_ready, o_we, o_addr, o_data, o_frame_done, o_drop_count
  );

  modport slave (
    input  i_valid, i_pixel_x, i_pixel_y, i_color, i_stall,
    output o_ready, o_we, o_addr, o_data, o_frame_done, o_drop_count
  );
endinterface

// File: rtl/pixel_writer.sv
// Buffers raymarcher pixels in a small FIFO and issues frame-buffer writes in order.
// Optional PIXEL_WRITER_BOUNDS_CHECK_EN drops off-screen pixels and counts them.
module pixel_writer #(
  parameter int unsigned H_RES      = 640,
  parameter int unsigned V_RES      = 480,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic            clk,
  input logic            reset,
  pixel_writer_if.slave  bus
);

  localparam int unsigned PtrW     = $clog2(FIFO_DEPTH);
  localparam logic [PtrW:0] FullCnt = (PtrW + 1)'(FIFO_DEPTH);
  localparam logic [18:0] LastAddr  = 19'(H_RES * V_RES - 1);

  typedef struct packed {
    logic [18:0] addr;
    logic [23:0] data;
  } entry_t;

  // Constant-coefficient shift-add; bits beyond 19 wrap away as required.
  function automatic logic [18:0] calc_addr(input logic [9:0] x, input logic [9:0] y);
    logic [18:0] acc;
    acc = {9'd0, x};
    for (int i = 0; i < 19; i++) begin
      if (H_RES[i]) acc = acc + ({9'd0, y} << i);
    end
    return acc;
  endfunction

  entry_t          mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]   cnt_q, cnt_d;
  logic            we_q, frame_done_q;
  logic [18:0]     addr_q;
  logic [23:0]     data_q;
  logic            accept, push, pop;
  entry_t          head;

  assign bus.o_ready = (cnt_q != FullCnt) & ~reset;
  assign accept      = bus.i_valid & bus.o_ready;
  assign pop         = (cnt_q != '0) & ~bus.i_stall;
  assign head        = mem_q[rd_ptr_q];

`ifdef PIXEL_WRITER_BOUNDS_CHECK_EN
  logic        in_range;
  logic [15:0] drop_q;

  assign in_range = ({22'd0, bus.i_pixel_x} < H_RES) && ({22'd0, bus.i_pixel_y} < V_RES);
  assign push     = accept & in_range;

  always_ff @(posedge clk) begin
    if (reset) begin
      drop_q <= '0;
    end else if (accept && !in_range && drop_q != 16'hFFFF) begin
      drop_q <= drop_q + 16'd1;
    end
  end

  assign bus.o_drop_count = drop_q;
`else
  assign push             = accept;
  assign bus.o_drop_count = '0;
`endif

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop) begin
      cnt_d = cnt_q + (PtrW + 1)'(1);
    end else if (!push && pop) begin
      cnt_d = cnt_q - (PtrW + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{addr: calc_addr(bus.i_pixel_x, bus.i_pixel_y), data: bus.i_color};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      we_q  <= pop;
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop) begin
        rd_ptr_q     <= rd_ptr_q + PtrW'(1);
        addr_q       <= head.addr;
        data_q       <= head.data;
        frame_done_q <= (head.addr == LastAddr);
      end else begin
        frame_done_q <= 1'b0;
      end
    end
  end

  assign bus.o_we         = we_q;
  assign bus.o_addr       = addr_q;
  assign bus.o_data       = data_q;
  assign bus.o_frame_done = frame_done_q;

endmodule

// File: doc/pixel_writer.md
PIXEL_WRITER -- requirements
Module: pixel_writer

Interface
REQ-001 Parameter H_RES, default 640, active pixels per line.
REQ-002 Parameter V_RES, default 480, active lines per frame.
REQ-003 Parameter FIFO_DEPTH, default 4, write-buffer entries (power of two, >=2).
REQ-004 clk  input  1  single clock for all logic.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 i_valid  input  1  raymarcher pixel valid.
REQ-007 i_pixel_x  input  10  pixel column.
REQ-008 i_pixel_y  input  10  pixel row.
REQ-009 i_color  input  24  {red, green, blue}, 8 bits each.
REQ-010 o_ready  output  1  block can accept a pixel this cycle.
REQ-011 i_stall  input  1  frame-buffer write port busy; no write may issue.
REQ-012 o_we  output  1  frame-buffer write enable.
REQ-013 o_addr  output  19  frame-buffer word address.
REQ-014 o_data  output  24  frame-buffer write data.
REQ-015 o_frame_done  output  1  one-cycle pulse on write of last pixel of frame.
REQ-016 o_drop_count  output  16  count of discarded out-of-range pixels.

Function
REQ-017 A pixel is accepted at a rising edge of clk where i_valid and o_ready are both high; nothing else consumes a pixel.
REQ-018 Address = i_pixel_y*H_RES + i_pixel_x, formed by shift-add (for 640: (y<<9)+(y<<7)+x), no hardware multiplier, truncated to 19 bits.
REQ-019 Accepted pixels are pushed, with address, into a FIFO_DEPTH-entry FIFO in acceptance order; write order equals acceptance order.
REQ-020 o_ready is high exactly when the FIFO is not full, derived from registered state only, with no combinational path from i_stall or i_valid.
REQ-021 FIFO full: o_ready low; i_valid ignored; upstream holds its pixel.
REQ-022 Issue: at an edge where the FIFO is non-empty and i_stall is low, the head pops and o_we/o_addr/o_data are registered with it; otherwise o_we registers low.
REQ-023 Latency: a pixel accepted into an empty FIFO at edge N with i_stall low at edge N+1 appears with o_we high in the cycle after edge N+1.
REQ-024 Sustained throughput one pixel per clock when i_stall stays low.
REQ-025 Simultaneous push and pop in one edge keeps occupancy unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-026 o_addr/o_data hold their last values while o_we is low.
REQ-027 o_frame_done is high for exactly the cycle in which o_we is high with o_addr = H_RES*V_RES-1.
REQ-028 o_drop_count saturates at 16'hFFFF.

Reset
REQ-029 While reset is high at an edge: FIFO emptied, all pointers zero, o_we=0, o_addr=0, o_data=0, o_frame_done=0, o_drop_count=0.
REQ-030 o_ready is 0 during reset and 1 from the first cycle after reset deasserts.
REQ-031 Reset mid-operation discards all buffered pixels; no write issues for them afterward.

Configuration
REQ-032 Macro PIXEL_WRITER_BOUNDS_CHECK_EN defined: pixels with x>=H_RES or y>=V_RES are accepted (handshake completes) but not pushed, and o_drop_count increments by 1 per such pixel.
REQ-033 Macro undefined: no bounds check; every accepted pixel is pushed with its truncated address; o_drop_count is constant 0.

Verification
REQ-034 Reset, then accept (x=0,y=0,color=24'hFF0000), i_stall low -> one cycle o_we=1, o_addr=0, o_data=24'hFF0000, o_frame_done=0.
REQ-035 Accept (639,479,24'h00FF00) -> o_addr=307199, o_data=24'h00FF00, o_frame_done high that cycle only.
REQ-036 Hold i_stall high, present 5 valid pixels -> 4 accepted, o_ready low after 4th, no o_we; release stall -> 4 writes on consecutive cycles in order, then 5th accepted and written.
REQ-037 Continuous valid (x=0..9, y=1), i_stall low -> 10 consecutive o_we cycles, addresses 640..649.
REQ-038 With PIXEL_WRITER_BOUNDS_CHECK_EN, send (640,0) and (0,480) -> both accepted, no o_we, o_drop_count=2; without macro -> two writes, addresses 640 and 307200 mod 2^19 = 307200.
REQ-039 Fill FIFO with 3 pixels under stall, assert reset one cycle -> o_we stays low after reset, o_ready=1, o_drop_count=0.
